burst_mem_responder: RTL



---
 rtl/mem_if_pkg.sv | 31 +++
 rtl/burst_addr_gen.sv | 40 ++++
 rtl/burst_mem_responder.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mem_if_pkg.sv
// Shared encodings for the clock/address/data_in/access_size/rw/enable/busy/data_out
// memory interface: burst sizes, rw polarity, default base address and responder states.
package mem_if_pkg;

   localparam logic [1:0] ACCESS_1  = 2'b00;
   localparam logic [1:0] ACCESS_4  = 2'b01;
   localparam logic [1:0] ACCESS_8  = 2'b10;
   localparam logic [1:0] ACCESS_16 = 2'b11;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h8002_0000;

   typedef enum logic [1:0] {
      IDLE,
      RBURST,
      WBURST
   } state_t;

   function automatic logic [4:0] size_to_n(input logic [1:0] size);
      case (size)
         ACCESS_1:  return 5'd1;
         ACCESS_4:  return 5'd4;
         ACCESS_8:  return 5'd8;
         ACCESS_16: return 5'd16;
         default:   return 5'd1;
      endcase
   endfunction

endpackage

// File: rtl/burst_addr_gen.sv
// Beat word-index generator and range check for burst_mem_responder.
// BURST_WRAP_EN selects critical-word-first wrapping within the aligned N-word block.
module burst_addr_gen
   import mem_if_pkg::*;
#(
   parameter int unsigned IW    = 33,
   parameter int unsigned WORDS = 262144,
   parameter int unsigned MW    = 18
) (
   input  logic signed [IW-1:0] start_idx,
   input  logic [4:0]           beat_n,
   input  logic [3:0]           beat_k,
   output logic [MW-1:0]        word_idx,
   output logic                 in_range
);

   logic signed [IW-1:0] lin_idx;
   logic signed [IW-1:0] beat_idx;
   logic [IW-1:0]        words_lim;

   assign lin_idx = start_idx + $signed({{(IW-4){1'b0}}, beat_k});

`ifdef BURST_WRAP_EN
   logic [IW-1:0] mask;

   // N is a power of two, so N-1 selects the offset bits inside the aligned block
   assign mask     = {{(IW-5){1'b0}}, beat_n - 5'd1};
   assign beat_idx = $signed(($unsigned(start_idx) & ~mask) | ($unsigned(lin_idx) & mask));
`else
   logic unused_n;

   assign unused_n = ^beat_n;
   assign beat_idx = lin_idx;
`endif

   assign words_lim = IW'(WORDS);
   assign in_range  = !beat_idx[IW-1] && ($unsigned(beat_idx) < words_lim);
   assign word_idx  = beat_idx[MW-1:0];

endmodule

// File: rtl/burst_mem_responder.sv
// Word-organised memory responder with registered busy, single/burst sequencing and
// sticky address-range error. Optional macro BURST_WRAP_EN enables wrapping bursts.
module burst_mem_responder
   import mem_if_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter int unsigned           ADDR_WIDTH  = 32,
   parameter int unsigned           DEPTH_BYTES = 1048576,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = BASE_ADDR_DEFAULT
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [1:0]            access_size,
   input  logic                  rw,
   input  logic                  enable,
   output logic                  busy,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  addr_err
);

   localparam int unsigned WORDS = DEPTH_BYTES / 4;
   localparam int unsigned MW    = $clog2(WORDS);
   localparam int unsigned IW    = ADDR_WIDTH + 1;

   state_t               state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [4:0]           n_q, req_n, beat_n;
   logic signed [IW-1:0] idx_q, req_idx, start_idx;
   logic [IW-1:0]        addr_diff;
   logic [3:0]           beat_k;
   logic [MW-1:0]        word_idx;
   logic                 in_range;
   logic                 accept;
   logic                 do_beat;
   logic                 beat_rw;

   logic [DATA_WIDTH-1:0] mem [WORDS];

   // Signed index so addresses below BASE_ADDR are detected as out of range
   assign addr_diff = {1'b0, address} - {1'b0, BASE_ADDR};
   assign req_idx   = $signed(addr_diff) >>> 2;
   assign req_n     = size_to_n(access_size);
   assign busy      = (state_q != IDLE);
   assign accept    = (state_q == IDLE) && enable;

   // Beat 0 comes straight from the request; later beats from the latched burst
   assign start_idx = busy ? idx_q : req_idx;
   assign beat_n    = busy ? n_q   : req_n;
   assign beat_k    = busy ? cnt_q : 4'd0;

   burst_addr_gen #(
      .IW    (IW),
      .WORDS (WORDS),
      .MW    (MW)
   ) u_addr_gen (
      .start_idx (start_idx),
      .beat_n    (beat_n),
      .beat_k    (beat_k),
      .word_idx  (word_idx),
      .in_range  (in_range)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      do_beat = 1'b0;
      beat_rw = RW_WRITE;
      case (state_q)
         IDLE: begin
            if (enable) begin
               do_beat = 1'b1;
               beat_rw = rw;
               if (req_n > 5'd1) begin
                  state_d = (rw == RW_READ) ? RBURST : WBURST;
                  cnt_d   = 4'd1;
               end
            end
         end
         RBURST, WBURST: begin
            do_beat = 1'b1;
            beat_rw = (state_q == RBURST) ? RW_READ : RW_WRITE;
            if ({1'b0, cnt_q} == n_q - 5'd1) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         n_q      <= 5'd1;
         idx_q    <= '0;
         data_out <= '0;
         addr_err <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            idx_q <= req_idx;
            n_q   <= req_n;
         end
         if (do_beat && (beat_rw == RW_READ)) begin
            data_out <= in_range ? mem[word_idx] : '0;
         end
         if (do_beat && !in_range) begin
            addr_err <= 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (do_beat && (beat_rw == RW_WRITE) && in_range) begin
         mem[word_idx] <= data_in;
      end
   end

endmodule
